// File: rtl/nrs_pkg.sv
// Shared types and constants for the NRS Gold-sequence producer.
package nrs_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WARM = 2'd1,
      GEN  = 2'd2,
      DONE = 2'd3
   } nrs_state_e;

   localparam int NRS_NC   = 1600;
   localparam int LFSR_LEN = 31;

   // Feedback taps relative to x(n): x1 uses {3,0}, x2 uses {3,2,1,0}
   localparam logic [LFSR_LEN-1:0] X1_TAPS = 31'h0000_0009;
   localparam logic [LFSR_LEN-1:0] X2_TAPS = 31'h0000_000F;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/nrs_lfsr31.sv
// 31-bit Fibonacci LFSR; bit 0 is x(n), the feedback bit enters at bit 30.
module nrs_lfsr31
   import nrs_pkg::*;
#(
   parameter logic [LFSR_LEN-1:0] TAPS = X1_TAPS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [LFSR_LEN-1:0] load_val,
   input  logic                shift,
   output logic [LFSR_LEN-1:0] state
);

   logic feedback;

   assign feedback = ^(state & TAPS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= '0;
      end else if (load) begin
         state <= load_val;
      end else if (shift) begin
         state <= {feedback, state[LFSR_LEN-1:1]};
      end
   end

endmodule

// File: rtl/nrs_gold_seq_gen.sv
// Gold-sequence c(n) producer: fast-forwards NC+SEQ_OFFSET bits, then writes
// WIDTH_REG bits into the NRS register, one per clock.
//
// state | meaning
// IDLE  | outputs low, waiting for start (samples c_init)
// WARM  | fast-forward both LFSRs for NC+SEQ_OFFSET cycles
// GEN   | one register write per cycle, wr_addr = cnt
// DONE  | one-cycle done pulse, then back to IDLE
module nrs_gold_seq_gen
   import nrs_pkg::*;
#(
   parameter int WIDTH_REG  = 16,
   parameter int LINES      = $clog2(WIDTH_REG),
   parameter int NC         = NRS_NC,
   parameter int SEQ_OFFSET = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [30:0]         c_init,
   output logic                wr_en,
   output logic [LINES-1:0]    wr_addr,
   output logic                c_n,
   output logic                busy,
   output logic                done
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_WARM = WARM;
   localparam logic [1:0] S_GEN  = GEN;
   localparam logic [1:0] S_DONE = DONE;

   localparam int WARM_LEN = NC + SEQ_OFFSET;
   // Wide enough for both phases so the counter can never wrap
   localparam int CNT_W = $clog2(max_int(WARM_LEN, WIDTH_REG) + 1);
   localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARM_LEN - 1);
   localparam logic [CNT_W-1:0] GEN_LAST  = CNT_W'(WIDTH_REG - 1);

   logic [1:0]          state;
   logic [CNT_W-1:0]    cnt;
   logic [LFSR_LEN-1:0] x1;
   logic [LFSR_LEN-1:0] x2;
   logic                lfsr_load;
   logic                lfsr_shift;
   logic                in_gen;

   assign lfsr_load  = (state == S_IDLE) && start;
   assign lfsr_shift = (state == S_WARM) || (state == S_GEN);

   nrs_lfsr31 #(.TAPS(X1_TAPS)) u_x1 (
      .clk      (clk),
      .rst      (rst),
      .load     (lfsr_load),
      .load_val (LFSR_LEN'(1)),
      .shift    (lfsr_shift),
      .state    (x1)
   );

   nrs_lfsr31 #(.TAPS(X2_TAPS)) u_x2 (
      .clk      (clk),
      .rst      (rst),
      .load     (lfsr_load),
      .load_val (c_init),
      .shift    (lfsr_shift),
      .state    (x2)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_WARM;
                  cnt   <= '0;
               end
            end
            S_WARM: begin
               if (cnt == WARM_LAST) begin
                  state <= S_GEN;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_GEN: begin
               if (cnt == GEN_LAST) begin
                  state <= S_DONE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Outputs decode from registers only; start/c_init never reach them
   always_comb begin
      in_gen  = (state == S_GEN);
      wr_en   = in_gen;
      wr_addr = in_gen ? cnt[LINES-1:0] : '0;
      c_n     = in_gen & (x1[0] ^ x2[0]);
      busy    = (state == S_WARM) || in_gen;
      done    = (state == S_DONE);
   end

endmodule

// File: tb/tb_nrs_gold_seq_gen.sv
// Scoreboard bench for nrs_gold_seq_gen: two instances (SEQ_OFFSET 0 and 212)
// checked against a Gold-sequence model built directly from the recurrences.
module tb_nrs_gold_seq_gen;
   import nrs_pkg::*;

   localparam int WR  = 16;
   localparam int OFF1 = 212;
   localparam int L0  = NRS_NC;
   localparam int L1  = NRS_NC + OFF1;

   typedef struct {
      int         cyc;
      bit         is_done;
      logic [3:0] addr;
      logic       b;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]        rst_v;
   logic [1:0]        start_v;
   logic [1:0][30:0]  c_init_v;
   logic [1:0]        wr_en_v;
   logic [1:0][3:0]   wr_addr_v;
   logic [1:0]        c_n_v;
   logic [1:0]        busy_v;
   logic [1:0]        done_v;

   nrs_gold_seq_gen #(.WIDTH_REG(WR), .NC(NRS_NC), .SEQ_OFFSET(0)) dut0 (
      .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .c_init(c_init_v[0]),
      .wr_en(wr_en_v[0]), .wr_addr(wr_addr_v[0]), .c_n(c_n_v[0]),
      .busy(busy_v[0]), .done(done_v[0])
   );

   nrs_gold_seq_gen #(.WIDTH_REG(WR), .NC(NRS_NC), .SEQ_OFFSET(OFF1)) dut1 (
      .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .c_init(c_init_v[1]),
      .wr_en(wr_en_v[1]), .wr_addr(wr_addr_v[1]), .c_n(c_n_v[1]),
      .busy(busy_v[1]), .done(done_v[1])
   );

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t q0[$];
   exp_t q1[$];
   int   off_len[2]    = '{L0, L1};
   int   done_cyc[2]   = '{-10, -10};
   int   busy_lo[2]    = '{0, 0};
   int   busy_hi[2]    = '{-1, -1};
   int   last_t[2]     = '{0, 0};
   int   writes_exp[2] = '{0, 0};
   int   writes_seen[2] = '{0, 0};

   always @(posedge clk) cyc <= cyc + 1;

   // c(L..L+15) straight from the x1/x2 recurrences
   function automatic logic [15:0] gold(input logic [30:0] ci, input int first);
      bit x1[];
      bit x2[];
      logic [15:0] g;
      int n_tot;
      n_tot = first + WR;
      x1 = new[n_tot + 31];
      x2 = new[n_tot + 31];
      for (int i = 0; i < 31; i++) begin
         x1[i] = (i == 0);
         x2[i] = ci[i];
      end
      for (int n = 0; n < n_tot; n++) begin
         x1[n+31] = x1[n+3] ^ x1[n];
         x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
      end
      for (int k = 0; k < WR; k++) g[k] = x1[first+k] ^ x2[first+k];
      return g;
   endfunction

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s inst=%0d cyc=%0d actual=%0h required=%0h", nm, i, cyc, act, req);
      end
   endtask

   function automatic int qsz(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t qfront(input int i);
      if (i == 0) return q0[0];
      return q1[0];
   endfunction

   task automatic qpop(input int i);
      if (i == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
   endtask

   task automatic qpush(input int i, input exp_t e);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic qflush(input int i);
      exp_t e;
      while (qsz(i) > 0) begin
         e = qfront(i);
         if (!e.is_done) writes_exp[i]--;
         qpop(i);
      end
   endtask

   task automatic monitor_inst(input int i);
      exp_t e;
      while (qsz(i) > 0 && qfront(i).cyc < cyc) begin
         e = qfront(i);
         checks++;
         failures++;
         $display("FAIL missed_output inst=%0d cyc=%0d actual=none required=%s at cyc %0d",
                  i, cyc, e.is_done ? "done" : "write", e.cyc);
         qpop(i);
      end
      if (wr_en_v[i]) writes_seen[i]++;
      if (wr_en_v[i] || done_v[i]) begin
         if (qsz(i) == 0 || qfront(i).cyc != cyc) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output inst=%0d cyc=%0d actual wr_en=%0b done=%0b addr=%0d required=no output",
                     i, cyc, wr_en_v[i], done_v[i], wr_addr_v[i]);
         end else begin
            e = qfront(i);
            qpop(i);
            if (e.is_done) begin
               chk("done_pulse", i, {wr_en_v[i], done_v[i]}, 32'b01);
            end else begin
               chk("wr_en_only", i, {wr_en_v[i], done_v[i]}, 32'b10);
               chk("wr_addr", i, wr_addr_v[i], e.addr);
               chk("c_n", i, c_n_v[i], e.b);
            end
         end
      end else begin
         chk("idle_addr_cn", i, {wr_addr_v[i], c_n_v[i]}, 32'h0);
      end
      chk("busy", i, busy_v[i], (cyc >= busy_lo[i] && cyc <= busy_hi[i]) ? 32'h1 : 32'h0);
   endtask

   always @(negedge clk) begin
      monitor_inst(0);
      monitor_inst(1);
   end

   task automatic wait_until(input int c);
      @(negedge clk);
      while (cyc < c) @(negedge clk);
   endtask

   // Drives start for one cycle; must be called just after a negedge
   task automatic pulse(input int i, input logic [30:0] ci);
      int t;
      logic [15:0] g;
      exp_t e;
      start_v[i]  = 1'b1;
      c_init_v[i] = ci;
      t = cyc + 1;
      if (t >= done_cyc[i] + 2) begin
         g = gold(ci, off_len[i]);
         last_t[i]   = t;
         busy_lo[i]  = t;
         busy_hi[i]  = t + off_len[i] + WR - 1;
         done_cyc[i] = t + off_len[i] + WR;
         for (int k = 0; k < WR; k++) begin
            e = '{cyc: t + off_len[i] + k, is_done: 1'b0, addr: 4'(k), b: g[k]};
            qpush(i, e);
            writes_exp[i]++;
         end
         e = '{cyc: done_cyc[i], is_done: 1'b1, addr: 4'd0, b: 1'b0};
         qpush(i, e);
      end
      @(negedge clk);
      start_v[i]  = 1'b0;
      c_init_v[i] = 31'($urandom());
   endtask

   initial begin
      int t;
      rst_v    = 2'b11;
      start_v  = 2'b00;
      c_init_v = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++)
         chk("reset_outputs", i, {wr_en_v[i], busy_v[i], done_v[i], c_n_v[i], wr_addr_v[i]}, 32'h0);
      rst_v = 2'b00;
      @(negedge clk);

      // Basic run, c_init for N_ID=0, ns=0, l=5
      pulse(0, 31'h3401);
      wait_until(done_cyc[0] + 2);

      // Same run with ignored starts in WARM cycle 800 and GEN cycle 5
      pulse(0, 31'h3401);
      t = last_t[0];
      wait_until(t + 800);
      pulse(0, 31'h1234567);
      wait_until(t + L0 + 5);
      pulse(0, 31'h7654321);
      wait_until(done_cyc[0] + 2);

      // Reset mid-GEN right after the write to address 7
      pulse(0, 31'($urandom()));
      t = last_t[0];
      wait_until(t + L0 + 7);
      @(posedge clk);
      #1;
      rst_v[0] = 1'b1;
      qflush(0);
      busy_hi[0]  = -1;
      done_cyc[0] = -10;
      #1;
      chk("rst_mid_gen", 0, {wr_en_v[0], busy_v[0], done_v[0], c_n_v[0], wr_addr_v[0]}, 32'h0);
      repeat (2) @(negedge clk);
      rst_v[0] = 1'b0;
      @(negedge clk);
      pulse(0, 31'($urandom()));

      // Start in DONE is ignored, start one cycle later launches
      wait_until(done_cyc[0]);
      pulse(0, 31'($urandom()));
      pulse(0, 31'($urandom()));

      // Back-to-back runs
      wait_until(done_cyc[0] + 1);
      pulse(0, 31'h1);
      wait_until(done_cyc[0] + 1);
      pulse(0, 31'h7FFF_FFFF);
      wait_until(done_cyc[0] + 3);

      // SEQ_OFFSET=212 with c_init=0: c(n) is x1 alone
      pulse(1, 31'h0);
      wait_until(done_cyc[1] + 3);

      for (int i = 0; i < 2; i++)
         chk("write_count", i, writes_seen[i], writes_exp[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
